rst_cond: RTL and testbench

RST_COND -- requirements
Module: rst_cond

---
 rtl/rst_pkg.sv | 15 +
 rtl/rst_sync_chain.sv | 26 ++
 rtl/rst_cond.sv | 129 ++++++++++++
 tb/tb_rst_cond.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types and default constants for the reset conditioner.
// No logic; imported by rst_sync_chain and rst_cond.
package rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_SOFT   = 2'd3
    } rst_state_e;

    localparam int RST_SYNC_STAGES_DEF = 2;
    localparam int RST_HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/rst_sync_chain.sv
// Reset deassertion synchronizer: async clear to 0, shifts 1 in from the bottom.
// Latency: SYNC_STAGES clk edges from rst_n release to sync_out high.
// Backpressure: none.
module rst_sync_chain
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = RST_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_cond.sv
// Reset conditioner: sync release, HOLD_CYCLES stretch, optional soft reset (RST_COND_SOFT_EN).
// Latency: rst_out_n rises SYNC_STAGES+HOLD_CYCLES+1 edges after rst_n release.
// Backpressure: none; soft_req is a level, acknowledged by a one-cycle soft_ack.
module rst_cond
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = RST_SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_req,
    output logic       rst_out_n,
    output logic       rst_done,
    output logic       soft_ack,
    output logic [7:0] rst_cnt,
    output logic [1:0] state
);

    localparam int             CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    rst_state_e    state_q;
    rst_state_e    state_d;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_d;
    logic          rst_out_n_q;
    logic          done_q;
    logic          done_d;
    logic          sync_out;
    logic          soft_go;
    logic          soft_take;

    rst_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_out (sync_out)
    );

`ifdef RST_COND_SOFT_EN
    assign soft_go = soft_req;
`else
    logic unused_soft_req;
    assign soft_go         = 1'b0;
    assign unused_soft_req = soft_req;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        done_d     = 1'b0;
        soft_take  = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (sync_out) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (soft_go) begin
                    state_d   = ST_SOFT;
                    soft_take = 1'b1;
                end
            end
            ST_SOFT: begin
                state_d    = ST_HOLD;
                hold_cnt_d = HOLD_LOAD;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    // rst_out_n is registered from the next state so it never sees rst_n or soft_req combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ASSERT;
            hold_cnt    <= '0;
            rst_out_n_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt    <= hold_cnt_d;
            rst_out_n_q <= (state_d == ST_RUN);
            done_q      <= done_d;
        end
    end

`ifdef RST_COND_SOFT_EN
    logic       ack_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            ack_q <= soft_take;
            if (soft_take && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign soft_ack = ack_q;
    assign rst_cnt  = cnt_q;
`else
    assign soft_ack = 1'b0;
    assign rst_cnt  = 8'd0;
`endif

    assign rst_out_n = rst_out_n_q;
    assign rst_done  = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rst_cond.sv
// Directed bench for rst_cond with a scoreboard of per-edge expected outputs.
// Soft reset scenarios are selected by RST_COND_SOFT_EN to match the build.
module tb_rst_cond;
    import rst_pkg::*;

    localparam int S   = 2;
    localparam int H   = 16;
    localparam int REL = 19;

    typedef struct packed {
        logic [1:0] st;
        logic       out_n;
        logic       done;
        logic       ack;
        logic [7:0] cnt;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       soft_req;
    logic       rst_out_n;
    logic       rst_done;
    logic       soft_ack;
    logic [7:0] rst_cnt;
    logic [1:0] state;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;

    rst_cond dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_req  (soft_req),
        .rst_out_n (rst_out_n),
        .rst_done  (rst_done),
        .soft_ack  (soft_ack),
        .rst_cnt   (rst_cnt),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input string tag, input logic [1:0] st, input logic o,
                            input logic d, input logic a, input logic [7:0] c);
        obs_t e;
        e.st    = st;
        e.out_n = o;
        e.done  = d;
        e.ack   = a;
        e.cnt   = c;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_front();
        obs_t  e;
        obs_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state, rst_out_n, rst_done, soft_ack, rst_cnt};
        checks++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: got st=%0d out_n=%b done=%b ack=%b cnt=%0d, want st=%0d out_n=%b done=%b ack=%b cnt=%0d",
                   t, o.st, o.out_n, o.done, o.ack, o.cnt, e.st, e.out_n, e.done, e.ack, e.cnt);
        end
    endtask

    // One clk edge: expectation queued, then checked 1 time unit after the edge.
    task automatic step(input string tag, input logic [1:0] st, input logic o,
                        input logic d, input logic a, input logic [7:0] c);
        push_exp(tag, st, o, d, a, c);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic now_chk(input string tag, input logic [1:0] st, input logic o,
                           input logic d, input logic a, input logic [7:0] c);
        push_exp(tag, st, o, d, a, c);
        compare_front();
    endtask

    // Called 1 unit after an edge; rst_n goes low at +2 and stays low for 'low' units.
    task automatic pulse_rst(input string tag, input int low);
        #1 rst_n = 1'b0;
        #1 now_chk(tag, ST_ASSERT, 1'b0, 1'b0, 1'b0, 8'd0);
        #(low - 1) rst_n = 1'b1;
    endtask

    task automatic release_seq(input string tag, input int last, input int on_e, input int off_e);
        for (int e = 1; e <= last; e++) begin
            step($sformatf("%s_e%0d", tag, e),
                 (e <= S) ? ST_ASSERT : ((e <= S + H) ? ST_HOLD : ST_RUN),
                 (e >= REL), (e == REL), 1'b0, 8'd0);
            if (e == on_e)  soft_req = 1'b1;
            if (e == off_e) soft_req = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        soft_req = 1'b0;
        @(posedge clk);
        #1;

        pulse_rst("por_low", 5);
        release_seq("rel", REL, 0, 0);
        step("rel_after", ST_RUN, 1'b1, 1'b0, 1'b0, 8'd0);

`ifdef RST_COND_SOFT_EN
        soft_req = 1'b1;
        step("soft_take", ST_SOFT, 1'b0, 1'b0, 1'b1, 8'd1);
        soft_req = 1'b0;
        for (int i = 0; i < H; i++) begin
            step($sformatf("soft_hold%0d", i), ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd1);
        end
        step("soft_rel", ST_RUN, 1'b1, 1'b1, 1'b0, 8'd1);
        step("soft_run", ST_RUN, 1'b1, 1'b0, 1'b0, 8'd1);
`else
        soft_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("nosoft%0d", i), ST_RUN, 1'b1, 1'b0, 1'b0, 8'd0);
        end
        soft_req = 1'b0;
`endif

        // soft_req held across most of HOLD: no ack, no stretch
        pulse_rst("hold_rst", 5);
        release_seq("holdign", REL, 4, 18);
        step("holdign_after", ST_RUN, 1'b1, 1'b0, 1'b0, 8'd0);

        // sub-period rst_n pulse landing mid-HOLD
        pulse_rst("pre_rst", 5);
        release_seq("pre", 11, 0, 0);
        checks++;
        assert (dut.hold_cnt === 7) passed++;
        else begin
            fails++;
            $error("FAIL hold_cnt_at_pulse: got %0d want 7", dut.hold_cnt);
        end
        pulse_rst("short_rst", 3);
        release_seq("short", REL, 0, 0);

`ifdef RST_COND_SOFT_EN
        soft_req = 1'b1;
        for (int r = 1; r <= 300; r++) begin
            logic [7:0] c;
            c = (r > 255) ? 8'd255 : 8'(r);
            step($sformatf("sat%0d_soft", r), ST_SOFT, 1'b0, 1'b0, 1'b1, c);
            for (int i = 0; i < H; i++) begin
                step($sformatf("sat%0d_hold", r), ST_HOLD, 1'b0, 1'b0, 1'b0, c);
            end
            step($sformatf("sat%0d_run", r), ST_RUN, 1'b1, 1'b1, 1'b0, c);
        end
        soft_req = 1'b0;
        step("sat_idle", ST_RUN, 1'b1, 1'b0, 1'b0, 8'd255);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
